// File: rtl/evt_readout_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// evt_readout_ctrl
//   Event readout sequencer. Pops one L1A entry, emits a 4-word header,
//   then for each of SAMP_MAX+1 samples reads all 16 channel FIFOs at once
//   and streams the 16 channel words. It ends the event with a trailer word
//   that carries the total word count. The output uses a valid/ready
//   handshake, and DAQ_DATA/DAQ_VALID hold steady while stalled.
//
//   Optional feature macro: DAQ_TIMEOUT_EN
//     When this macro is defined, waiting in SMP_RD for non-empty channel
//     FIFOs is bounded by TMO_LIMIT cycles. On expiry the event is closed
//     with an F trailer and the sticky ERR flag is set. When the macro is
//     undefined, the block waits forever and ERR is tied low.
//
// Parameters
//   TMO_LIMIT      stall cycles in SMP_RD before abort (timeout build only)
// Ports
//   RDCLK          clock, all logic on rising edge
//   RST            synchronous active-high reset
//   SAMP_MAX[6:0]  samples per event minus one, latched at event start
//   RDY            L1A sample FIFO not empty
//   L1A_SMP_OUT    {phase, match, l1amcnt[11:0], l1acnt[23:0]}
//   OVRLP_SMP_OUT  overlap status of the popped L1A entry
//   DOUT_16CH      16 x 12-bit channel FIFO data, ch N at [12N+11:12N]
//   FMT[15:0]      channel FIFO empty flags
//   RD_ENA[15:0]   channel FIFO read enables
//   L1A_RD_EN      L1A FIFO read enable
//   DAQ_DATA       output word
//   DAQ_VALID      output word valid
//   DAQ_READY      downstream accepts word
//   BUSY           high whenever the FSM is not idle
//   EVT_CNT        completed event counter (wraps)
//   ERR            sticky timeout flag
// ---------------------------------------------------------------------------
module evt_readout_ctrl #(
    parameter int TMO_LIMIT = 4095
) (
    input  logic         RDCLK,
    input  logic         RST,
    input  logic [6:0]   SAMP_MAX,
    input  logic         RDY,
    input  logic [37:0]  L1A_SMP_OUT,
    input  logic [6:0]   OVRLP_SMP_OUT,
    input  logic [191:0] DOUT_16CH,
    input  logic [15:0]  FMT,
    output logic [15:0]  RD_ENA,
    output logic         L1A_RD_EN,
    output logic [15:0]  DAQ_DATA,
    output logic         DAQ_VALID,
    input  logic         DAQ_READY,
    output logic         BUSY,
    output logic [15:0]  EVT_CNT,
    output logic         ERR
);

    // A limit below 2 leaves no room for a single stall cycle.
    if (TMO_LIMIT < 2) begin : g_tmo_chk
        $error("TMO_LIMIT must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE, HDR_RD, HDR_WT, HDR_OUT, SMP_RD, SMP_CAP, SMP_OUT, TRL
    } state_t;

    state_t state, state_nxt;

    logic [6:0]        smax_q;     // latched SAMP_MAX for this event
    logic [6:0]        smp_idx;    // current sample number
    logic [3:0]        ch_idx;     // current channel in SMP_OUT
    logic [1:0]        hdr_idx;    // current header word
    logic [11:0]       wcnt;       // words accepted so far this event
    logic [37:0]       l1a_q;
    logic [6:0]        ovrlp_q;
    logic [15:0][11:0] smp_q;      // one captured sample, all channels
    logic [15:0]       evt_cnt_q;
    logic              out_vld;
    logic              xfer;
    logic [3:0]        trl_nib;

`ifdef DAQ_TIMEOUT_EN
    localparam int            TMO_W    = $clog2(TMO_LIMIT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);

    logic [TMO_W-1:0] stall_cnt;
    logic             tmo_hit;
    logic             tmo_q;       // this event ended on a timeout
    logic             err_q;

    assign trl_nib = tmo_q ? 4'hF : 4'hE;
    assign ERR     = err_q;
`else
    assign trl_nib = 4'hE;
    assign ERR     = 1'b0;
`endif

    // Valid depends only on state, so DAQ_DATA/DAQ_VALID cannot change
    // while a word is stalled: nothing advances without xfer.
    assign out_vld = ~RST & ((state == HDR_OUT) | (state == SMP_OUT) | (state == TRL));
    assign xfer    = out_vld & DAQ_READY;
    assign BUSY    = (state != IDLE);
    assign EVT_CNT = evt_cnt_q;

    always_ff @(posedge RDCLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        RD_ENA    = '0;
        L1A_RD_EN = 1'b0;
        DAQ_VALID = out_vld;
        DAQ_DATA  = '0;
`ifdef DAQ_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (RDY) state_nxt = HDR_RD;
            end
            HDR_RD: begin
                L1A_RD_EN = 1'b1;
                state_nxt = HDR_WT;
            end
            HDR_WT: begin
                // L1A FIFO output becomes valid this cycle and is
                // registered on the edge that leaves this state.
                state_nxt = HDR_OUT;
            end
            HDR_OUT: begin
                case (hdr_idx)
                    2'd0:    DAQ_DATA = {4'hA, l1a_q[23:12]};
                    2'd1:    DAQ_DATA = {4'hA, l1a_q[11:0]};
                    2'd2:    DAQ_DATA = {4'hB, l1a_q[35:24]};
                    default: DAQ_DATA = {4'hC, l1a_q[37], l1a_q[36], 3'b000, ovrlp_q};
                endcase
                if (xfer && hdr_idx == 2'd3) state_nxt = SMP_RD;
            end
            SMP_RD: begin
                if (FMT == 16'h0000) begin
                    RD_ENA    = 16'hFFFF;
                    state_nxt = SMP_CAP;
                end
`ifdef DAQ_TIMEOUT_EN
                else if (stall_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = TRL;
                end
`endif
            end
            SMP_CAP: begin
                state_nxt = SMP_OUT;
            end
            SMP_OUT: begin
                DAQ_DATA = {ch_idx, smp_q[ch_idx]};
                if (xfer && ch_idx == 4'hF)
                    state_nxt = (smp_idx == smax_q) ? TRL : SMP_RD;
            end
            TRL: begin
                // Count includes the trailer itself.
                DAQ_DATA = {trl_nib, wcnt + 12'd1};
                if (xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Strobes and data are forced low during reset, even in the cycle
        // before the state register clears.
        if (RST) begin
            RD_ENA    = '0;
            L1A_RD_EN = 1'b0;
            DAQ_DATA  = '0;
        end
    end

    always_ff @(posedge RDCLK) begin
        if (RST) begin
            smax_q    <= '0;
            smp_idx   <= '0;
            ch_idx    <= '0;
            hdr_idx   <= '0;
            wcnt      <= '0;
            l1a_q     <= '0;
            ovrlp_q   <= '0;
            smp_q     <= '0;
            evt_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (RDY) begin
                        smax_q  <= SAMP_MAX;
                        smp_idx <= '0;
                        ch_idx  <= '0;
                        hdr_idx <= '0;
                        wcnt    <= '0;
                    end
                end
                HDR_WT: begin
                    l1a_q   <= L1A_SMP_OUT;
                    ovrlp_q <= OVRLP_SMP_OUT;
                end
                HDR_OUT: begin
                    if (xfer) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        wcnt    <= wcnt + 12'd1;
                    end
                end
                SMP_CAP: begin
                    smp_q <= DOUT_16CH;
                end
                SMP_OUT: begin
                    if (xfer) begin
                        ch_idx <= ch_idx + 4'd1;   // wraps to 0 after ch15
                        wcnt   <= wcnt + 12'd1;
                        if (ch_idx == 4'hF && smp_idx != smax_q)
                            smp_idx <= smp_idx + 7'd1;
                    end
                end
                TRL: begin
                    if (xfer) evt_cnt_q <= evt_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DAQ_TIMEOUT_EN
    always_ff @(posedge RDCLK) begin
        if (RST) begin
            stall_cnt <= '0;
            tmo_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Counts cycles spent in SMP_RD; restarts on every entry.
            if (state == SMP_RD) stall_cnt <= stall_cnt + 1'b1;
            else                 stall_cnt <= '0;
            if (state == IDLE && RDY) tmo_q <= 1'b0;
            if (tmo_hit) begin
                tmo_q <= 1'b1;
                err_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_evt_readout_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_evt_readout_ctrl
//   Scoreboard bench for evt_readout_ctrl. Upstream FIFOs are modelled as
//   queues that present data one cycle after their read enable. Each queued
//   event pushes its expected output words; a negedge monitor pops and
//   compares on every accepted word and also checks strobe rules and
//   hold-while-stalled behaviour.
// ---------------------------------------------------------------------------
module tb_evt_readout_ctrl;

    logic         RDCLK;
    logic         RST;
    logic [6:0]   SAMP_MAX;
    logic         RDY;
    logic [37:0]  L1A_SMP_OUT;
    logic [6:0]   OVRLP_SMP_OUT;
    logic [191:0] DOUT_16CH;
    logic [15:0]  FMT;
    logic [15:0]  RD_ENA;
    logic         L1A_RD_EN;
    logic [15:0]  DAQ_DATA;
    logic         DAQ_VALID;
    logic         DAQ_READY;
    logic         BUSY;
    logic [15:0]  EVT_CNT;
    logic         ERR;

    evt_readout_ctrl #(.TMO_LIMIT(16)) dut (
        .RDCLK(RDCLK), .RST(RST), .SAMP_MAX(SAMP_MAX), .RDY(RDY),
        .L1A_SMP_OUT(L1A_SMP_OUT), .OVRLP_SMP_OUT(OVRLP_SMP_OUT),
        .DOUT_16CH(DOUT_16CH), .FMT(FMT), .RD_ENA(RD_ENA),
        .L1A_RD_EN(L1A_RD_EN), .DAQ_DATA(DAQ_DATA), .DAQ_VALID(DAQ_VALID),
        .DAQ_READY(DAQ_READY), .BUSY(BUSY), .EVT_CNT(EVT_CNT), .ERR(ERR)
    );

`ifdef DAQ_TIMEOUT_EN
    localparam int STALL_LEN = 10;   // stays below the 16-cycle timeout
`else
    localparam int STALL_LEN = 50;
`endif

    int n_pass = 0, n_total = 0;
    int xfer_cnt = 0, l1a_pops = 0, rd_pops = 0;
    int rdy_mode = 0;                // 0: always ready, 1: toggle, 2: random
    int fmt_mode = 0;                // 0: random empties, 1: forced value
    logic [15:0] fmt_force = '0;
    logic        l1a_pend = 0, rd_pend = 0;
    logic        prev_stall = 0;
    logic [15:0] prev_data = '0;

    logic [16:0]  expq[$];           // {last_of_event, word}
    logic [37:0]  l1aq[$];
    logic [6:0]   ovq[$];
    logic [6:0]   smaxq[$];
    logic [191:0] chq[$];

    initial begin
        RDCLK = 0;
        forever #5 RDCLK = ~RDCLK;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference model: builds the event's output stream from the field
    // values with plain arithmetic and queues the upstream FIFO contents.
    task automatic push_event(input int l1acnt, input int l1amcnt, input int phase,
                              input int match, input int ovrlp, input int smax,
                              input bit tmo);
        logic [191:0] d;
        int           s [16];
        l1aq.push_back({1'(phase), 1'(match), 12'(l1amcnt), 24'(l1acnt)});
        ovq.push_back(7'(ovrlp));
        smaxq.push_back(7'(smax));
        expq.push_back({1'b0, 16'(16'hA000 + l1acnt / 4096)});
        expq.push_back({1'b0, 16'(16'hA000 + l1acnt % 4096)});
        expq.push_back({1'b0, 16'(16'hB000 + l1amcnt)});
        expq.push_back({1'b0, 16'(16'hC000 + phase * 2048 + match * 1024 + ovrlp)});
        if (tmo) begin
`ifdef DAQ_TIMEOUT_EN
            expq.push_back({1'b1, 16'(16'hF000 + 5)});
`endif
        end else begin
            for (int k = 0; k <= smax; k++) begin
                for (int c = 0; c < 16; c++) begin
                    s[c] = $urandom_range(0, 4095);
                    d[c*12 +: 12] = 12'(s[c]);
                    expq.push_back({1'b0, 16'(c * 4096 + s[c])});
                end
                chq.push_back(d);
            end
            expq.push_back({1'b1, 16'(16'hE000 + 4 + 16 * (smax + 1) + 1)});
        end
    endtask

    // Upstream FIFO responder and input drivers, updated just after each edge.
    initial begin
        RDY = 0;
        SAMP_MAX = '0;
        FMT = '0;
        DAQ_READY = 1;
        OVRLP_SMP_OUT = 7'($urandom);
        L1A_SMP_OUT = 38'({$urandom(), $urandom()});
        for (int k = 0; k < 6; k++) DOUT_16CH[k*32 +: 32] = $urandom();
        forever begin
            @(posedge RDCLK);
            #1;
            if (l1a_pend) begin
                l1a_pops++;
                if (l1aq.size() == 0) fail_now("l1a_fifo_underflow");
                else begin
                    L1A_SMP_OUT   = l1aq.pop_front();
                    OVRLP_SMP_OUT = ovq.pop_front();
                    smaxq.delete(0);
                end
            end
            if (rd_pend) begin
                rd_pops++;
                if (chq.size() == 0) fail_now("ch_fifo_underflow");
                else DOUT_16CH = chq.pop_front();
            end
            RDY = (l1aq.size() != 0);
            SAMP_MAX = (smaxq.size() != 0) ? smaxq[0] : 7'($urandom);
            case (rdy_mode)
                0:       DAQ_READY = 1'b1;
                1:       DAQ_READY = ~DAQ_READY;
                default: DAQ_READY = 1'($urandom_range(0, 1));
            endcase
            if (fmt_mode == 1) FMT = fmt_force;
            else FMT = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
        end
    end

    // Monitor: scoreboard pop on every accepted word plus protocol rules.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge RDCLK);
            if (RST) begin
                check("strobe_in_rst", {L1A_RD_EN, RD_ENA}, '0);
                prev_stall = 0;
                l1a_pend = 0;
                rd_pend = 0;
            end else begin
                if (L1A_RD_EN && RD_ENA != 0) fail_now("rd_ena_and_l1a_rd_en_together");
                if (RD_ENA != 0) begin
                    check("rd_ena_value", RD_ENA, 16'hFFFF);
                    check("rd_ena_while_fmt", FMT, 16'h0);
                end
                if (prev_stall) begin
                    check("hold_valid", DAQ_VALID, 1'b1);
                    check("hold_data", DAQ_DATA, prev_data);
                end
                if (DAQ_VALID && DAQ_READY) begin
                    xfer_cnt++;
                    if (expq.size() == 0) fail_now($sformatf("extra_word %h", DAQ_DATA));
                    else begin
                        e = expq.pop_front();
                        check("daq_word", DAQ_DATA, e[15:0]);
                    end
                end
                prev_stall = DAQ_VALID && !DAQ_READY;
                prev_data  = DAQ_DATA;
                l1a_pend   = L1A_RD_EN;
                rd_pend    = (RD_ENA != 0);
            end
        end
    end

    task automatic wait_idle(input string nm, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge RDCLK);
            #2;
            if (expq.size() == 0 && !BUSY) begin ok = 1; break; end
        end
        if (!ok) fail_now({nm, "_timeout"});
    endtask

    task automatic wait_xfer(input string nm, input int target, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge RDCLK);
            #2;
            if (xfer_cnt >= target) begin ok = 1; break; end
        end
        if (!ok) fail_now({nm, "_timeout"});
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_strobes"}, {L1A_RD_EN, RD_ENA}, '0);
        check({nm, "_daq"}, {DAQ_VALID, DAQ_DATA}, '0);
        check({nm, "_status"}, {BUSY, ERR, EVT_CNT}, '0);
    endtask

    initial begin
        int base, nrd, sm;
        RST = 1;
        repeat (2) @(posedge RDCLK);
        #2;
        check_quiet("reset");
        RST = 0;

        // Directed event, always ready.
        l1a_pops = 0; rd_pops = 0;
        push_event(24'h123456, 12'hABC, 1, 1, 7'h05, 1, 0);
        wait_idle("t1", 3000);
        check("t1_evt_cnt", EVT_CNT, 16'd1);
        check("t1_l1a_pops", l1a_pops, 1);
        check("t1_rd_pops", rd_pops, 2);

        // Same event with READY toggling.
        rdy_mode = 1;
        l1a_pops = 0; rd_pops = 0;
        push_event(24'h123456, 12'hABC, 1, 1, 7'h05, 1, 0);
        wait_idle("t2", 3000);
        check("t2_evt_cnt", EVT_CNT, 16'd2);
        check("t2_rd_pops", rd_pops, 2);

        // Channel 7 empty for a long stretch at sample 0.
        rdy_mode = 0;
        fmt_force = 16'h0080; fmt_mode = 1;
        l1a_pops = 0; rd_pops = 0;
        base = xfer_cnt;
        push_event($urandom_range(0, 24'hFFFFFF), $urandom_range(0, 4095), 0, 1, 7'h7F, 1, 0);
        wait_xfer("t3_hdr", base + 4, 500);
        repeat (STALL_LEN) @(posedge RDCLK);
        #2;
        check("t3_no_rd_during_stall", rd_pops, 0);
        check("t3_busy_during_stall", BUSY, 1'b1);
        check("t3_no_valid_during_stall", DAQ_VALID, 1'b0);
        fmt_mode = 0;
        wait_idle("t3", 3000);
        check("t3_rd_pops", rd_pops, 2);
        check("t3_evt_cnt", EVT_CNT, 16'd3);

        // Random back-to-back events with random READY and empties.
        rdy_mode = 2;
        l1a_pops = 0; rd_pops = 0; nrd = 0;
        for (int i = 0; i < 12; i++) begin
            sm = (i == 5) ? 20 : $urandom_range(0, 3);
            nrd += sm + 1;
            push_event($urandom_range(0, 24'hFFFFFF), $urandom_range(0, 4095),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 127), sm, 0);
        end
        wait_idle("t4", 30000);
        check("t4_evt_cnt", EVT_CNT, 16'd15);
        check("t4_l1a_pops", l1a_pops, 12);
        check("t4_rd_pops", rd_pops, nrd);
        check("t4_err", ERR, 1'b0);

        // Reset while data word 10 of sample 0 is on the bus.
        rdy_mode = 0;
        base = xfer_cnt;
        push_event(24'h00ABCD, 12'h321, 0, 0, 7'h11, 1, 0);
        wait_xfer("t5_words", base + 14, 500);
        RST = 1;
        @(negedge RDCLK);
        expq.delete(); l1aq.delete(); ovq.delete(); smaxq.delete(); chq.delete();
        @(posedge RDCLK);
        #2;
        check_quiet("t5_after_rst");
        RST = 0;
        l1a_pops = 0; rd_pops = 0;
        push_event(24'hA5A5A5, 12'h0F0, 1, 0, 7'h2A, 0, 0);
        wait_idle("t5", 3000);
        check("t5_evt_cnt", EVT_CNT, 16'd1);
        check("t5_rd_pops", rd_pops, 1);

        // Channel FIFOs never fill.
        fmt_force = 16'hFFFF; fmt_mode = 1;
        rd_pops = 0;
        base = xfer_cnt;
        push_event(24'h000001, 12'h002, 0, 0, 7'h00, 0, 1);
`ifdef DAQ_TIMEOUT_EN
        wait_idle("t6", 500);
        check("t6_err", ERR, 1'b1);
        check("t6_evt_cnt", EVT_CNT, 16'd2);
        check("t6_rd_pops", rd_pops, 0);
`else
        wait_xfer("t6_hdr", base + 4, 500);
        repeat (100) @(posedge RDCLK);
        #2;
        check("t6_busy", BUSY, 1'b1);
        check("t6_no_valid", DAQ_VALID, 1'b0);
        check("t6_no_trailer", expq.size(), 0);
        check("t6_evt_cnt", EVT_CNT, 16'd1);
        check("t6_rd_pops", rd_pops, 0);
        check("t6_err", ERR, 1'b0);
        RST = 1;
        @(posedge RDCLK);
        #2;
        RST = 0;
        check("t6_busy_after_rst", BUSY, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        fail_now("watchdog");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/evt_readout_ctrl.md
EVT_READOUT_CTRL -- requirements
Module: evt_readout_ctrl

Interface
REQ-001 Parameter: TMO_LIMIT, 4095, stall cycles before event abort (used only with DAQ_TIMEOUT_EN).
REQ-002 RDCLK  in  1  sole clock; all logic on posedge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 SAMP_MAX  in  7  samples per event minus 1; latched at event start.
REQ-005 RDY  in  1  L1A sample FIFO not empty.
REQ-006 L1A_SMP_OUT  in  38  {phase[37], match[36], l1amcnt[35:24], l1acnt[23:0]}.
REQ-007 OVRLP_SMP_OUT  in  7  overlap status of popped L1A entry.
REQ-008 DOUT_16CH  in  192  channel FIFO data; ch N at [12N+11:12N].
REQ-009 FMT  in  16  channel FIFO empty flags.
REQ-010 RD_ENA  out  16  channel FIFO read enables.
REQ-011 L1A_RD_EN  out  1  L1A sample FIFO read enable.
REQ-012 DAQ_DATA  out  16  output word.
REQ-013 DAQ_VALID  out  1  DAQ_DATA valid.
REQ-014 DAQ_READY  in  1  downstream accepts word.
REQ-015 BUSY  out  1  high in every state except IDLE.
REQ-016 EVT_CNT  out  16  completed events, wraps 0xFFFF->0x0000.
REQ-017 ERR  out  1  sticky timeout flag.

Function
REQ-018 States: IDLE, HDR_RD, HDR_WT, HDR_OUT, SMP_RD, SMP_CAP, SMP_OUT, TRL.
REQ-019 IDLE: RDY=1 -> HDR_RD, latch SAMP_MAX, clear word and sample counters.
REQ-020 HDR_RD: L1A_RD_EN=1 for exactly one cycle (T); HDR_WT at T+1; capture L1A_SMP_OUT and OVRLP_SMP_OUT at T+2; enter HDR_OUT.
REQ-021 HDR_OUT words in order: {A,l1acnt[23:12]}, {A,l1acnt[11:0]}, {B,l1amcnt}, {C,phase,match,3'b000,ovrlp[6:0]}.
REQ-022 SMP_RD: when FMT==16'h0000, RD_ENA=16'hFFFF one cycle; else RD_ENA=0, stay.
REQ-023 SMP_CAP: capture DOUT_16CH the cycle after RD_ENA pulse; enter SMP_OUT.
REQ-024 SMP_OUT emits 16 words {ch[3:0], data[11:0]}, ch 0..15 ascending.
REQ-025 After ch15 accepted: sample==latched SAMP_MAX -> TRL; else sample+1 -> SMP_RD.
REQ-026 TRL word {E, wordcount[11:0]}; wordcount = 4+16*(SAMP_MAX+1)+1 including trailer; max 2053 fits 12 bits.
REQ-027 Trailer acceptance: EVT_CNT+1, IDLE; next event may start the following cycle.
REQ-028 Handshake: transfer iff DAQ_VALID&DAQ_READY; while VALID&~READY, DAQ_DATA and DAQ_VALID hold stable.
REQ-029 DAQ_VALID=1 only in HDR_OUT, SMP_OUT, TRL; never asserted with invalid data.
REQ-030 Exactly one L1A_RD_EN pulse and SAMP_MAX+1 RD_ENA pulses per completed event.
REQ-031 RD_ENA and L1A_RD_EN never asserted simultaneously, never asserted during RST.

Reset
REQ-032 RST: state IDLE; RD_ENA=0, L1A_RD_EN=0, DAQ_DATA=0, DAQ_VALID=0, BUSY=0, EVT_CNT=0, ERR=0, counters 0.
REQ-033 RST mid-event abandons event, no trailer emitted; upstream FIFO flush is not this block's job.

Configuration
REQ-034 Macro DAQ_TIMEOUT_EN defined: in SMP_RD a stall counter resets on entry; reaching TMO_LIMIT -> TRL with {F,wordcount}, count = words emitted incl. trailer; ERR=1 until RST; remaining samples not read.
REQ-035 DAQ_TIMEOUT_EN undefined: SMP_RD waits indefinitely, trailer nibble always E, ERR tied 0, no counter logic.

Verification
REQ-036 RST 2 cycles -> all outputs 0, BUSY=0, state IDLE.
REQ-037 SAMP_MAX=1, l1acnt=0x123456, l1amcnt=0xABC, phase=1, match=1, OVRLP=0x05, READY=1 -> A123, A456, BABC, CC05, 32 data words, E025; EVT_CNT=1; one L1A_RD_EN, two RD_ENA=FFFF.
REQ-038 Same event, DAQ_READY toggling 1/0 -> identical word sequence, DAQ_DATA stable during stalls, none lost or duplicated.
REQ-039 FMT[7]=1 for 50 cycles at sample 0 -> RD_ENA=0 throughout, normal readout after clear.
REQ-040 DAQ_TIMEOUT_EN, TMO_LIMIT=16, SAMP_MAX=0, FMT stuck 0xFFFF -> after 16 cycles F005, ERR=1, EVT_CNT=1; without macro, no trailer, BUSY stays 1.
REQ-041 RST asserted at data word 10 -> outputs 0 next cycle; next event header begins A with no trailer for aborted event.
